// File: rtl/i2c_slave_addr_detect_pkg.sv
// Shared types for the I2C slave address front end.
// State encoding of the address-phase FSM and the general-call byte value.
// Imported by the top; no logic lives here.
package i2c_addr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK,
    DATA,
    IGNORE
  } addr_states_t;

  localparam logic [7:0] GEN_CALL_ADDR = 8'h00;

endpackage

// File: rtl/i2c_slave_addr_detect_sync.sv
// Pin synchroniser: SYNC_STAGES flop chain bringing a raw I2C pin into FPGA_clk.
// Latency: SYNC_STAGES cycles from pin to output.
// Resets to 1 so an idle (pulled-up) bus is presented while rst is held.
module i2c_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic FPGA_clk,
  input  logic rst,
  input  logic pin_in,
  output logic pin_sync
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw pin into the bottom of the chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
  end

  // Chain register, idle-high reset
  always_ff @(posedge FPGA_clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pin_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2c_slave_addr_detect.sv
// I2C slave front end: pin sync, START/STOP detect, address match, address ACK, data-in enable.
// Latency: pins->SCL/SDA SYNC_STAGES cycles; detect pulses one cycle after the synced condition.
// No backpressure; optional general-call acceptance is built with macro GENERAL_CALL_EN.
module i2c_slave_addr_detect
  import i2c_addr_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic FPGA_clk,
  input  logic rst,
  input  logic SCL_in,
  input  logic SDA_in,
  output logic SCL,
  output logic SCL_prev,
  output logic SDA,
  output logic SDA_prev,
  output logic start_det,
  output logic stop_det,
  output logic addr_match,
  output logic rw,
  output logic gen_call,
  output logic SDA_down,
  output logic data_en,
  output logic busy
);

  logic scl_s, sda_s;
  logic scl_prev_q, scl_prev_d;
  logic sda_prev_q, sda_prev_d;

  addr_states_t state_q, state_d;
  logic [7:0]   shift_q, shift_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic         byte_full_q, byte_full_d;
  logic         start_det_q, start_det_d;
  logic         stop_det_q, stop_det_d;
  logic         addr_match_q, addr_match_d;
  logic         rw_q, rw_d;
  logic         sda_down_q, sda_down_d;
  logic         data_en_q, data_en_d;
  logic         busy_q, busy_d;

`ifdef GENERAL_CALL_EN
  logic         gen_call_q, gen_call_d;
`endif

  logic scl_rise, scl_fall, start_c, stop_c, slave_hit;

  i2c_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
    .FPGA_clk (FPGA_clk),
    .rst      (rst),
    .pin_in   (SCL_in),
    .pin_sync (scl_s)
  );

  i2c_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
    .FPGA_clk (FPGA_clk),
    .rst      (rst),
    .pin_in   (SDA_in),
    .pin_sync (sda_s)
  );

  // SDA can only form START/STOP while SCL is stable high, so an SDA edge
  // coincident with an SCL edge is never mistaken for a bus condition.
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign start_c  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_c   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  // A general-call byte is never claimed through the plain address path,
  // which only matters if SLAVE_ADDR is ever set to 0.
  assign slave_hit = (shift_q[7:1] == SLAVE_ADDR) && (shift_q != GEN_CALL_ADDR);

  // Next-state and output decode; START/STOP override every state transition
  always_comb begin
    scl_prev_d   = scl_s;
    sda_prev_d   = sda_s;
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    byte_full_d  = byte_full_q;
    start_det_d  = 1'b0;
    stop_det_d   = 1'b0;
    addr_match_d = 1'b0;
    rw_d         = rw_q;
    sda_down_d   = sda_down_q;
    data_en_d    = data_en_q;
    busy_d       = busy_q;
`ifdef GENERAL_CALL_EN
    gen_call_d   = gen_call_q;
`endif

    if (start_c) begin
      start_det_d = 1'b1;
      busy_d      = 1'b1;
      data_en_d   = 1'b0;
      sda_down_d  = 1'b0;
      bit_cnt_d   = 3'd0;
      shift_d     = 8'h00;
      byte_full_d = 1'b0;
      state_d     = ADDR;
    end else if (stop_c) begin
      stop_det_d  = 1'b1;
      busy_d      = 1'b0;
      data_en_d   = 1'b0;
      sda_down_d  = 1'b0;
      byte_full_d = 1'b0;
      state_d     = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
        end
        ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            // The 3-bit counter wraps on the 8th bit; remember the byte is complete
            if (bit_cnt_q == 3'd7) begin
              byte_full_d = 1'b1;
            end
          end else if (scl_fall && byte_full_q) begin
            byte_full_d = 1'b0;
            if (slave_hit) begin
              rw_d         = shift_q[0];
              addr_match_d = 1'b1;
              sda_down_d   = 1'b1;
              state_d      = ACK;
`ifdef GENERAL_CALL_EN
              gen_call_d   = 1'b0;
            end else if (shift_q == GEN_CALL_ADDR) begin
              rw_d         = 1'b0;
              gen_call_d   = 1'b1;
              addr_match_d = 1'b1;
              sda_down_d   = 1'b1;
              state_d      = ACK;
`endif
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ACK: begin
          // Hold the ACK through the 9th SCL high, hand over at its falling edge
          if (scl_fall) begin
            sda_down_d = 1'b0;
            data_en_d  = 1'b1;
            state_d    = DATA;
          end
        end
        DATA: begin
          data_en_d = 1'b1;
        end
        IGNORE: begin
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers; idle-bus values on reset
  always_ff @(posedge FPGA_clk or posedge rst) begin
    if (rst) begin
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      state_q      <= IDLE;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      byte_full_q  <= 1'b0;
      start_det_q  <= 1'b0;
      stop_det_q   <= 1'b0;
      addr_match_q <= 1'b0;
      rw_q         <= 1'b0;
      sda_down_q   <= 1'b0;
      data_en_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      scl_prev_q   <= scl_prev_d;
      sda_prev_q   <= sda_prev_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_full_q  <= byte_full_d;
      start_det_q  <= start_det_d;
      stop_det_q   <= stop_det_d;
      addr_match_q <= addr_match_d;
      rw_q         <= rw_d;
      sda_down_q   <= sda_down_d;
      data_en_q    <= data_en_d;
      busy_q       <= busy_d;
    end
  end

`ifdef GENERAL_CALL_EN
  // General-call flag register
  always_ff @(posedge FPGA_clk or posedge rst) begin
    if (rst) begin
      gen_call_q <= 1'b0;
    end else begin
      gen_call_q <= gen_call_d;
    end
  end
  assign gen_call = gen_call_q;
`else
  assign gen_call = 1'b0;
`endif

  assign SCL        = scl_s;
  assign SCL_prev   = scl_prev_q;
  assign SDA        = sda_s;
  assign SDA_prev   = sda_prev_q;
  assign start_det  = start_det_q;
  assign stop_det   = stop_det_q;
  assign addr_match = addr_match_q;
  assign rw         = rw_q;
  assign SDA_down   = sda_down_q;
  assign data_en    = data_en_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_addr_detect.sv
// Bench for i2c_slave_addr_detect: table of address bytes plus hand-timed corner sequences.
module tb_i2c_slave_addr_detect;
  import i2c_addr_pkg::*;

  localparam int H = 6;  // SCL half-period in FPGA_clk cycles

  logic FPGA_clk = 1'b0;
  logic rst, SCL_in, SDA_in;
  logic SCL, SCL_prev, SDA, SDA_prev, start_det, stop_det, addr_match;
  logic rw, gen_call, SDA_down, data_en, busy;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0, stop_cnt = 0, match_cnt = 0, ack_cyc = 0, den_cyc = 0;

  typedef struct {
    logic [7:0] byte_v;
    logic       exp_match;
    logic       exp_rw;
    logic       exp_gc;
  } vec_t;
  vec_t vecs[6];

  i2c_slave_addr_detect #(.SLAVE_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .FPGA_clk   (FPGA_clk),
    .rst        (rst),
    .SCL_in     (SCL_in),
    .SDA_in     (SDA_in),
    .SCL        (SCL),
    .SCL_prev   (SCL_prev),
    .SDA        (SDA),
    .SDA_prev   (SDA_prev),
    .start_det  (start_det),
    .stop_det   (stop_det),
    .addr_match (addr_match),
    .rw         (rw),
    .gen_call   (gen_call),
    .SDA_down   (SDA_down),
    .data_en    (data_en),
    .busy       (busy)
  );

  always #5 FPGA_clk = ~FPGA_clk;

  // Pulse and level-cycle counters sampled away from the active edge
  always @(negedge FPGA_clk) begin
    if (start_det === 1'b1)  start_cnt++;
    if (stop_det === 1'b1)   stop_cnt++;
    if (addr_match === 1'b1) match_cnt++;
    if (SDA_down === 1'b1)   ack_cyc++;
    if (data_en === 1'b1)    den_cyc++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge FPGA_clk);
      #1;
    end
  endtask

  task automatic smp();
    @(negedge FPGA_clk);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Eight address bits MSB first; leaves SCL high after the 8th rise
  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      SDA_in = b[i];
      step(H);
      SCL_in = 1'b1;
      step(H);
      if (i > 0) begin
        SCL_in = 1'b0;
        step(H);
      end
    end
  endtask

  // Full transaction: START, address byte, ACK clock, one data bit, STOP
  task automatic xfer(input logic [7:0] b, output int d_start, output int d_stop,
                      output int d_match, output int d_ack, output int d_den,
                      output logic busy_mid);
    int s0, p0, m0, a0, e0;
    SCL_in = 1'b1;
    SDA_in = 1'b1;
    step(8);
    s0 = start_cnt; p0 = stop_cnt; m0 = match_cnt; a0 = ack_cyc; e0 = den_cyc;
    SDA_in = 1'b0; step(H);
    SCL_in = 1'b0; step(H);
    send_bits(b);
    SCL_in = 1'b0; step(H);            // 8th fall
    SDA_in = 1'b1; step(H);
    SCL_in = 1'b1; step(H);
    SCL_in = 1'b0; step(H);            // 9th fall
    SDA_in = 1'b0; step(H);
    SCL_in = 1'b1; step(H);
    smp();
    busy_mid = busy;
    SCL_in = 1'b0; step(H);
    SDA_in = 1'b0; step(H);
    SCL_in = 1'b1; step(H);
    SDA_in = 1'b1; step(H);            // STOP
    step(4);
    d_start = start_cnt - s0;
    d_stop  = stop_cnt - p0;
    d_match = match_cnt - m0;
    d_ack   = ack_cyc - a0;
    d_den   = den_cyc - e0;
  endtask

  initial begin
    int ds, dp, dm, da, de, m0;
    logic bm;

    vecs[0] = '{8'h84, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h85, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h86, 1'b0, 1'b1, 1'b0};
`ifdef GENERAL_CALL_EN
    vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b1};
`else
    vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b0};
`endif
    vecs[4] = '{8'h84, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h42, 1'b0, 1'b0, 1'b0};

    // Reset with pins low: outputs must show an idle bus
    rst = 1'b1; SCL_in = 1'b0; SDA_in = 1'b0;
    step(3); smp();
    chk("rst_SCL", SCL, 1); chk("rst_SCL_prev", SCL_prev, 1);
    chk("rst_SDA", SDA, 1); chk("rst_SDA_prev", SDA_prev, 1);
    chk("rst_start_det", start_det, 0); chk("rst_stop_det", stop_det, 0);
    chk("rst_addr_match", addr_match, 0); chk("rst_rw", rw, 0);
    chk("rst_gen_call", gen_call, 0); chk("rst_SDA_down", SDA_down, 0);
    chk("rst_data_en", data_en, 0); chk("rst_busy", busy, 0);
    chk("rst_state", 8'(dut.state_q), 8'(IDLE));
    SCL_in = 1'b1; SDA_in = 1'b1;
    step(3);
    rst = 1'b0;
    step(6);

    // START timing: pulse exactly 3 edges after SDA falls at the pin
    SDA_in = 1'b0;
    step(2); smp(); chk("start_early", start_det, 0);
    step(1); smp(); chk("start_pulse", start_det, 1); chk("start_busy", busy, 1);
    step(1); smp(); chk("start_width", start_det, 0);
    step(H);
    SCL_in = 1'b0; step(H);
    send_bits(8'h84);
    SCL_in = 1'b0;                     // 8th fall
    step(2); smp(); chk("ack_early", SDA_down, 0); chk("match_early", addr_match, 0);
    step(1); smp(); chk("ack_on", SDA_down, 1); chk("match_pulse", addr_match, 1);
    chk("match_rw", rw, 0);
    step(1); smp(); chk("match_width", addr_match, 0);
    step(H);
    SDA_in = 1'b1; step(H);
    SCL_in = 1'b1; step(H);
    smp(); chk("ack_hold_9th_high", SDA_down, 1);
    SCL_in = 1'b0;                     // 9th fall
    step(2); smp(); chk("ack_still", SDA_down, 1); chk("den_early", data_en, 0);
    step(1); smp(); chk("ack_off", SDA_down, 0); chk("den_on", data_en, 1);
    step(H);

    // Repeated START while in DATA
    SCL_in = 1'b1; step(H);
    SDA_in = 1'b0;
    step(2); smp(); chk("rs_den_hold", data_en, 1); chk("rs_start_early", start_det, 0);
    step(1); smp(); chk("rs_den_drop", data_en, 0); chk("rs_start_pulse", start_det, 1);
    step(H);
    SCL_in = 1'b0; step(H);
    m0 = match_cnt;
    send_bits(8'h84);
    SCL_in = 1'b0; step(H);
    smp();
    chk("rs_rematch", 8'(match_cnt - m0), 1);
    chk("rs_ack", SDA_down, 1);

    // Reset during ACK releases SDA_down without waiting for a clock edge
    rst = 1'b1;
    #1;
    chk("midrst_SDA_down", SDA_down, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_state", 8'(dut.state_q), 8'(IDLE));
    SCL_in = 1'b1; SDA_in = 1'b1;
    step(3);
    rst = 1'b0;
    step(4);

    // Table of address bytes, each a full transaction
    for (int i = 0; i < 6; i++) begin
      xfer(vecs[i].byte_v, ds, dp, dm, da, de, bm);
      smp();
      chk($sformatf("v%0d_start", i), 8'(ds), 1);
      chk($sformatf("v%0d_stop", i), 8'(dp), 1);
      chk($sformatf("v%0d_match", i), 8'(dm), vecs[i].exp_match ? 8'd1 : 8'd0);
      chk($sformatf("v%0d_ack_cycles", i), 8'(da), vecs[i].exp_match ? 8'd18 : 8'd0);
      chk($sformatf("v%0d_den_cycles", i), 8'(de), vecs[i].exp_match ? 8'd36 : 8'd0);
      chk($sformatf("v%0d_busy_mid", i), bm, 1);
      chk($sformatf("v%0d_busy_end", i), busy, 0);
      chk($sformatf("v%0d_rw", i), rw, vecs[i].exp_rw);
      chk($sformatf("v%0d_gen_call", i), gen_call, vecs[i].exp_gc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
